// File: rtl/divider_pkg.sv
// Shared types and helpers for the restoring divider.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Iteration counter width; never narrower than one bit.
  function automatic int cnt_width(input int size);
    return (size <= 2) ? 1 : $clog2(size);
  endfunction

endpackage

// File: rtl/div_trial_sub.sv
// Trial subtraction for one restoring-division step.
module div_trial_sub #(
  parameter int size = 8
) (
  input  logic [size:0]   shifted,
  input  logic [size-1:0] divisor,
  output logic [size-1:0] diff,
  output logic            ge
);

  logic [size:0] full_diff;

  // Subtract the divisor from the shifted partial remainder; MSB clear means non-negative.
  always_comb begin
    full_diff = shifted - {1'b0, divisor};
    diff      = full_diff[size-1:0];
    ge        = ~full_diff[size];
  end

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
//
// state | meaning
// IDLE  | waiting for start; previous results held
// RUN   | one shift-subtract iteration per clock
// DONE  | results valid and done pulsed; a zero divisor spends one settle
//       | cycle here first so its done lands one edge after start
module restoring_divider
  import divider_pkg::*;
#(
  parameter int size = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [size-1:0] dividend,
  input  logic [size-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [size-1:0] quotient,
  output logic [size-1:0] remainder,
  output logic            div_by_zero
);

  localparam int CW = cnt_width(size);

  state_e          state_q, state_d;
  // The partial remainder always stays below the divisor, so its top bit is
  // always zero and only the low size bits are stored.
  logic [size-1:0] r_q, r_d;
  logic [size-1:0] q_q, q_d;
  logic [size-1:0] dvsr_q, dvsr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            zpend_q, zpend_d;
  logic [size-1:0] quotient_q, quotient_d;
  logic [size-1:0] remainder_q, remainder_d;
  logic            dz_q, dz_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [size:0]   shifted;
  logic [size-1:0] diff;
  logic            ge;

  assign shifted = {r_q, q_q[size-1]};

  div_trial_sub #(.size(size)) u_trial (
    .shifted (shifted),
    .divisor (dvsr_q),
    .diff    (diff),
    .ge      (ge)
  );

  // Next-state, iteration and result-load logic.
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    q_d         = q_q;
    dvsr_d      = dvsr_q;
    cnt_d       = cnt_q;
    zpend_d     = zpend_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dz_d        = dz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          dvsr_d = divisor;
          q_d    = dividend;
          r_d    = '0;
          cnt_d  = '0;
          dz_d   = 1'b0;
          if (divisor == '0) begin
            state_d = DONE;
            zpend_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        r_d   = ge ? diff : shifted[size-1:0];
        q_d   = {q_q[size-2:0], ge};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(size - 1)) begin
          state_d     = DONE;
          cnt_d       = '0;
          quotient_d  = q_d;
          remainder_d = r_d;
        end
      end
      DONE: begin
        if (zpend_q) begin
          zpend_d     = 1'b0;
          quotient_d  = '1;
          remainder_d = q_q;
          dz_d        = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE) && !zpend_d;
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      r_q         <= '0;
      q_q         <= '0;
      dvsr_q      <= '0;
      cnt_q       <= '0;
      zpend_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dz_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      q_q         <= q_d;
      dvsr_q      <= dvsr_d;
      cnt_q       <= cnt_d;
      zpend_q     <= zpend_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dz_q        <= dz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dz_q;

endmodule
